// File: rtl/siganfu_fire_controller_if.sv
// Signal bundle between the fire controller and its radar / operator / gun environment.
//   slave  : the fire controller (consumes radar, operator and gun inputs, drives gun controls)
//   master : the environment (drives contact, engagement request and gun feedback)
// Radar/operator in : contact_valid, contact_hostile, track_quality[3:0], engage_req, burst_len[4:0]
// Gun feedback in   : gun_fire_trigger, gun_crit_alert
// Gun controls out  : target_locked, is_enemy, fire_command, firing_mode
// Status out        : ctrl_state[2:0], rounds_fired[7:0], magazines_left[3:0], engage_done,
//                     ammo_empty, abort
interface siganfu_fire_controller_if;
  logic       contact_valid;
  logic       contact_hostile;
  logic [3:0] track_quality;
  logic       engage_req;
  logic [4:0] burst_len;
  logic       gun_fire_trigger;
  logic       gun_crit_alert;
  logic       target_locked;
  logic       is_enemy;
  logic       fire_command;
  logic       firing_mode;
  logic [2:0] ctrl_state;
  logic [7:0] rounds_fired;
  logic [3:0] magazines_left;
  logic       engage_done;
  logic       ammo_empty;
  logic       abort;

  modport master (
    output contact_valid, contact_hostile, track_quality, engage_req, burst_len,
    output gun_fire_trigger, gun_crit_alert,
    input  target_locked, is_enemy, fire_command, firing_mode, ctrl_state, rounds_fired,
    input  magazines_left, engage_done, ammo_empty, abort
  );

  modport slave (
    input  contact_valid, contact_hostile, track_quality, engage_req, burst_len,
    input  gun_fire_trigger, gun_crit_alert,
    output target_locked, is_enemy, fire_command, firing_mode, ctrl_state, rounds_fired,
    output magazines_left, engage_done, ammo_empty, abort
  );
endinterface

// File: rtl/siganfu_fire_controller.sv
// Upstream fire-control unit for the siganfu machine gun.
// Qualifies a radar track into target_locked / is_enemy, sequences single, burst and full-auto
// engagements through fire_command / firing_mode, counts rounds from the gun's fire_trigger,
// tracks magazine reserve and stands down on the gun's criticality alert.
// Ports:
//   sysclk : system clock, rising edge
//   reboot : synchronous active-high reset
//   bus    : siganfu_fire_controller_if.slave (radar, operator, gun feedback in; gun controls
//            and status out). All outputs are registered.
module siganfu_fire_controller #(
  parameter int unsigned LOCK_THRESH   = 8,
  parameter int unsigned LOCK_HOLD     = 3,
  parameter int unsigned MAG_SIZE      = 25,
  parameter int unsigned MAGAZINES     = 4,
  parameter int unsigned REACQ_TIMEOUT = 16
) (
  input logic                      sysclk,
  input logic                      reboot,
  siganfu_fire_controller_if.slave bus
);

  localparam int unsigned LockW  = $clog2(LOCK_HOLD + 1);
  localparam int unsigned TimerW = $clog2(REACQ_TIMEOUT + 1);
  localparam int unsigned MagW   = $clog2(MAG_SIZE + 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StEngage   = 3'd1,
    StReacq    = 3'd2,
    StComplete = 3'd3,
    StEmpty    = 3'd4,
    StAbort    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [MagW-1:0]   mag_rounds_q, mag_rounds_d;
  logic [4:0]        burst_target_q, burst_target_d;
  logic [7:0]        rounds_q, rounds_d;
  logic [3:0]        mags_q, mags_d;
  logic              empty_q, empty_d;
  logic              trig_q;
  logic              locked_q, enemy_q, fire_q, mode_q, done_q, abort_q;

  logic qualify, trig_edge, target_ok, burst_hit, start;

  // Lock qualification and trigger edge detection.
  always_comb begin
    qualify   = bus.contact_valid && (bus.track_quality >= 4'(LOCK_THRESH));
    trig_edge = bus.gun_fire_trigger && !trig_q;
    if (!qualify) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q == LockW'(LOCK_HOLD)) begin
      lock_cnt_d = lock_cnt_q;
    end else begin
      lock_cnt_d = lock_cnt_q + LockW'(1);
    end
  end

  // Engagement sequencing; decisions use the registered lock/enemy/ammo view.
  always_comb begin
    target_ok      = locked_q && enemy_q;
    burst_hit      = (burst_target_q != 5'd0) && (rounds_q == {3'b000, burst_target_q});
    state_d        = state_q;
    timer_d        = timer_q;
    burst_target_d = burst_target_q;
    start          = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.gun_crit_alert) begin
          state_d = StAbort;
        end else if (bus.engage_req && target_ok && !empty_q) begin
          state_d        = StEngage;
          burst_target_d = bus.burst_len;
          start          = 1'b1;
        end
      end
      StEngage: begin
        if (bus.gun_crit_alert) begin
          state_d = StAbort;
        end else if (empty_q) begin
          state_d = StEmpty;
        end else if (burst_hit || !bus.engage_req) begin
          state_d = StComplete;
        end else if (!target_ok) begin
          state_d = StReacq;
          timer_d = '0;
        end
      end
      StReacq: begin
        if (bus.gun_crit_alert) begin
          state_d = StAbort;
        end else if (empty_q) begin
          state_d = StEmpty;
        end else if (target_ok) begin
          state_d = StEngage;
        end else if ((timer_q == TimerW'(REACQ_TIMEOUT)) || !bus.engage_req) begin
          state_d = StComplete;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StComplete: state_d = StIdle;
      StEmpty:    state_d = StEmpty;
      StAbort:    if (!bus.gun_crit_alert) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Round accounting runs in every state so late trigger edges still drain the magazine.
  always_comb begin
    rounds_d     = rounds_q;
    mag_rounds_d = mag_rounds_q;
    mags_d       = mags_q;
    empty_d      = empty_q;
    if (trig_edge) begin
      if (rounds_q != 8'hff) rounds_d = rounds_q + 8'd1;
      if (!empty_q) begin
        if (mag_rounds_q == MagW'(MAG_SIZE - 1)) begin
          if (mags_q != 4'd0) begin
            mags_d       = mags_q - 4'd1;
            mag_rounds_d = '0;
          end else begin
            empty_d      = 1'b1;
            mag_rounds_d = MagW'(MAG_SIZE);
          end
        end else begin
          mag_rounds_d = mag_rounds_q + MagW'(1);
        end
      end
    end
    // A new engagement starts its round count from zero.
    if (start) rounds_d = 8'd0;
  end

  always_ff @(posedge sysclk) begin
    if (reboot) begin
      state_q        <= StIdle;
      lock_cnt_q     <= '0;
      timer_q        <= '0;
      mag_rounds_q   <= '0;
      burst_target_q <= 5'd0;
      rounds_q       <= 8'd0;
      mags_q         <= 4'(MAGAZINES);
      empty_q        <= 1'b0;
      trig_q         <= 1'b0;
      locked_q       <= 1'b0;
      enemy_q        <= 1'b0;
      fire_q         <= 1'b0;
      mode_q         <= 1'b0;
      done_q         <= 1'b0;
      abort_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      lock_cnt_q     <= lock_cnt_d;
      timer_q        <= timer_d;
      mag_rounds_q   <= mag_rounds_d;
      burst_target_q <= burst_target_d;
      rounds_q       <= rounds_d;
      mags_q         <= mags_d;
      empty_q        <= empty_d;
      trig_q         <= bus.gun_fire_trigger;
      locked_q       <= (lock_cnt_d == LockW'(LOCK_HOLD));
      enemy_q        <= bus.contact_valid && bus.contact_hostile;
      // Outputs follow the state being entered so they change with the state itself.
      fire_q         <= (state_d == StEngage);
      mode_q         <= (state_d == StEngage) && (burst_target_d != 5'd1);
      done_q         <= (state_d == StComplete);
      abort_q        <= (state_d == StAbort);
    end
  end

  assign bus.target_locked  = locked_q;
  assign bus.is_enemy       = enemy_q;
  assign bus.fire_command   = fire_q;
  assign bus.firing_mode    = mode_q;
  assign bus.ctrl_state     = state_q;
  assign bus.rounds_fired   = rounds_q;
  assign bus.magazines_left = mags_q;
  assign bus.engage_done    = done_q;
  assign bus.ammo_empty     = empty_q;
  assign bus.abort          = abort_q;

endmodule
